// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit for a MIPS-style pipeline: a radix-2
// shift-add multiplier and restoring divider sharing one working register pair.
module muldiv_ctrl #(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        hilo_rd,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [63:0] prod,
    output logic        div_zero
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        CALC  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [4:0]  cnt_r;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r, hi_r, lo_r;
    logic        neg_q_r, neg_r_r, bz_r, dz_r;
    logic [63:0] prod_r;

    logic        busy_s, early_s, cap_s, fix_ld_s, early_ld_s;
    logic [32:0] mul_sum_s, div_tmp_s, div_diff_s;
    logic        div_ok_s;
    logic [63:0] fix_val_s, early_val_s;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    // Zero-operand / divide-by-zero shortcut decided on the raw request operands.
    always_comb begin
        early_s = 1'b0;
        if (EARLY_OUT) begin
            if (op[1]) begin
                early_s = (src_b == 32'd0);
            end else begin
                early_s = (src_a == 32'd0) || (src_b == 32'd0);
            end
        end else begin
            early_s = 1'b0;
        end
    end

    assign busy_s      = (state_r == PREP) || (state_r == CALC) || (state_r == FIXUP);
    assign cap_s       = start && !flush && ((state_r == IDLE) || (state_r == DONE));
    assign fix_ld_s    = (state_r == FIXUP) && !flush;
    assign early_ld_s  = (state_r == IDLE) && start && !flush && early_s;
    assign early_val_s = op[1] ? {src_a, 32'hFFFF_FFFF} : 64'd0;

    // One iteration step: multiply adds into HI then shifts right; divide shifts left then trial-subtracts.
    assign mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : 33'd0);
    assign div_tmp_s  = {hi_r, lo_r[31]};
    assign div_ok_s   = (div_tmp_s >= {1'b0, b_r});
    assign div_diff_s = div_tmp_s - {1'b0, b_r};

    // Sign correction and result packing applied during FIXUP.
    always_comb begin
        fix_val_s = {hi_r, lo_r};
        if (op_r[1]) begin
            if (bz_r) begin
                fix_val_s = {a_r, 32'hFFFF_FFFF};
            end else begin
                fix_val_s = {cond_neg32(hi_r, neg_r_r), cond_neg32(lo_r, neg_q_r)};
            end
        end else begin
            fix_val_s = neg_q_r ? (64'd0 - {hi_r, lo_r}) : {hi_r, lo_r};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; flush wins over everything, including a new start.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_s = start ? (early_s ? DONE : PREP) : IDLE;
                PREP:    state_s = CALC;
                CALC:    state_s = (cnt_r == 5'd31) ? FIXUP : CALC;
                FIXUP:   state_s = DONE;
                DONE:    state_s = start ? PREP : IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Operand capture and iterative working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 5'd0;
            op_r    <= 2'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            bz_r    <= 1'b0;
        end else begin
            if (cap_s) begin
                op_r <= op;
                a_r  <= src_a;
                b_r  <= src_b;
            end
            case (state_r)
                PREP: begin
                    hi_r    <= 32'd0;
                    lo_r    <= abs32(a_r, op_r[0]);
                    b_r     <= abs32(b_r, op_r[0]);
                    neg_q_r <= op_r[0] && (a_r[31] ^ b_r[31]);
                    neg_r_r <= op_r[0] && a_r[31];
                    bz_r    <= (b_r == 32'd0);
                    cnt_r   <= 5'd0;
                end
                CALC: begin
                    cnt_r <= cnt_r + 5'd1;
                    if (op_r[1]) begin
                        hi_r <= div_ok_s ? div_diff_s[31:0] : div_tmp_s[31:0];
                        lo_r <= {lo_r[30:0], div_ok_s};
                    end else begin
                        hi_r <= mul_sum_s[32:1];
                        lo_r <= {mul_sum_s[0], lo_r[31:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // HI/LO result register: result loads take priority over MTHI/MTLO writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r <= 64'd0;
            dz_r   <= 1'b0;
        end else if (fix_ld_s) begin
            prod_r <= fix_val_s;
            dz_r   <= op_r[1] && bz_r;
        end else if (early_ld_s) begin
            prod_r <= early_val_s;
            dz_r   <= op[1];
        end else begin
            if (wr_hi && !busy_s) begin
                prod_r[63:32] <= wr_data;
            end
            if (wr_lo && !busy_s) begin
                prod_r[31:0] <= wr_data;
            end
        end
    end

    assign busy     = busy_s;
    assign done     = (state_r == DONE);
    assign div_zero = (state_r == DONE) && dz_r;
    assign stall    = busy_s && (start || hilo_rd || wr_hi || wr_lo);
    assign prod     = prod_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: an early-out instance and an iterative-only
// instance share stimulus; each operation is checked on both.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = 32'd0, src_b = 32'd0;
    logic        flush = 1'b0, hilo_rd = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic [31:0] wr_data = 32'd0;

    logic        busy, stall, done, div_zero;
    logic [63:0] prod;
    logic        busy_it, stall_it, done_it, div_zero_it;
    logic [63:0] prod_it;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.EARLY_OUT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .hilo_rd(hilo_rd), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .stall(stall), .done(done), .prod(prod), .div_zero(div_zero)
    );

    muldiv_ctrl #(.EARLY_OUT(1'b0)) dut_it (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .hilo_rd(hilo_rd), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy_it), .stall(stall_it), .done(done_it), .prod(prod_it), .div_zero(div_zero_it)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation; cycle N is the cycle after the Nth edge following the start edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int dc, output logic [63:0] p, output logic dz,
                         output int bfirst, output int blast,
                         output int dc_it, output logic [63:0] p_it, output logic dz_it);
        int i;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1 start = 1'b0;
        dc = -1; dc_it = -1; bfirst = -1; blast = -1;
        p = 64'd0; p_it = 64'd0; dz = 1'b0; dz_it = 1'b0;
        i = 1;
        while (i <= 60 && (dc < 0 || dc_it < 0)) begin
            @(negedge clk);
            if (busy) begin
                if (bfirst < 0) bfirst = i;
                blast = i;
            end
            if (done && dc < 0) begin
                dc = i; p = prod; dz = div_zero;
            end
            if (done_it && dc_it < 0) begin
                dc_it = i; p_it = prod_it; dz_it = div_zero_it;
            end
            i++;
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        logic        dz;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int dc, dc_it, bf, bl, cnt;
        logic [63:0] p, p_it;
        logic dz, dz_it;

        vecs[0] = '{"mult_neg3x7",  2'b01, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, 35, 1'b0};
        vecs[1] = '{"div_neg7by2",  2'b11, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 35, 1'b0};
        vecs[2] = '{"divu_100by7",  2'b10, 32'd100,       32'd7,        64'h0000_0002_0000_000E, 35, 1'b0};
        vecs[3] = '{"divu_5by0",    2'b10, 32'd5,         32'd0,        64'h0000_0005_FFFF_FFFF,  1, 1'b1};
        vecs[4] = '{"div_min_by_m1",2'b11, 32'h8000_0000, 32'hFFFF_FFFF,64'h0000_0000_8000_0000, 35, 1'b0};
        vecs[5] = '{"multu_0x5",    2'b00, 32'd0,         32'd5,        64'h0,                    1, 1'b0};
        vecs[6] = '{"multu_max",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,64'hFFFF_FFFE_0000_0001, 35, 1'b0};
        vecs[7] = '{"div_neg7by0",  2'b11, 32'hFFFF_FFF9, 32'd0,        64'hFFFF_FFF9_FFFF_FFFF,  1, 1'b1};

        #12;
        check_val("rst_prod", prod, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_stall", {63'd0, stall}, 64'd0);
        check_val("rst_divzero", {63'd0, div_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            do_op(vecs[k].o, vecs[k].a, vecs[k].b, dc, p, dz, bf, bl, dc_it, p_it, dz_it);
            check_val({vecs[k].name, "_lat"}, dc, vecs[k].lat);
            check_val({vecs[k].name, "_prod"}, p, vecs[k].exp);
            check_val({vecs[k].name, "_dz"}, {63'd0, dz}, {63'd0, vecs[k].dz});
            check_val({vecs[k].name, "_it_lat"}, dc_it, 35);
            check_val({vecs[k].name, "_it_prod"}, p_it, vecs[k].exp);
            check_val({vecs[k].name, "_it_dz"}, {63'd0, dz_it}, {63'd0, vecs[k].dz});
            if (vecs[k].lat == 35) begin
                check_val({vecs[k].name, "_busy_first"}, bf, 1);
                check_val({vecs[k].name, "_busy_last"}, bl, 34);
            end
            @(negedge clk);
            check_val({vecs[k].name, "_done_pulse"}, {63'd0, done}, 64'd0);
        end

        // hilo_rd held from cycle 3 of a MULTU: stall until the DONE cycle.
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'd6; src_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            hilo_rd = (i >= 3);
            #1;
            if (i == 2)  check_val("stall_c2", {63'd0, stall}, 64'd0);
            if (i == 3)  check_val("stall_c3", {63'd0, stall}, 64'd1);
            if (i == 34) check_val("stall_c34", {63'd0, stall}, 64'd1);
            if (i == 35) begin
                check_val("stall_c35", {63'd0, stall}, 64'd0);
                check_val("stall_done", {63'd0, done}, 64'd1);
                check_val("stall_prod", prod, 64'd42);
            end
        end
        hilo_rd = 1'b0;

        // Flush at cycle 10 of a DIV: no done, prod kept.
        @(negedge clk);
        start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 10; i++) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_val("flush_busy", {63'd0, busy}, 64'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || done_it) cnt++;
        end
        check_val("flush_no_done", cnt, 0);
        check_val("flush_prod", prod, 64'd42);

        // Reset mid-operation: immediate clear, no done afterwards.
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 5; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", {63'd0, busy}, 64'd0);
        check_val("arst_prod", prod, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || done_it) cnt++;
        end
        check_val("arst_no_done", cnt, 0);
        check_val("arst_prod_after", prod, 64'd0);

        // MTHI/MTLO while idle, then an MTLO attempt while busy.
        wr_hi = 1'b1; wr_data = 32'hCAFE_F00D;
        @(posedge clk);
        #1 wr_hi = 1'b0;
        check_val("wr_hi_idle", prod, 64'hCAFE_F00D_0000_0000);
        @(negedge clk);
        wr_lo = 1'b1; wr_data = 32'h1234_5678;
        @(posedge clk);
        #1 wr_lo = 1'b0;
        check_val("wr_lo_idle", prod, 64'hCAFE_F00D_1234_5678);
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 5; i++) @(negedge clk);
        wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
        #1;
        check_val("wr_busy_stall", {63'd0, stall}, 64'd1);
        @(posedge clk);
        #1 wr_lo = 1'b0;
        check_val("wr_busy_nowrite", prod, 64'hCAFE_F00D_1234_5678);
        dc = -1;
        for (int i = 6; i <= 60 && dc < 0; i++) begin
            @(negedge clk);
            if (done) dc = i;
        end
        check_val("wr_op_lat", dc, 35);
        check_val("wr_op_prod", prod, 64'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter: EARLY_OUT, 1, when 1 a MULT/MULTU with a zero operand or any divide by zero completes without iterating.
REQ-002 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  in  1  EX-stage request to begin an operation, sampled on clk.
REQ-005 SHALL have port: op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
REQ-006 SHALL have port: src_a  in  32  multiplicand or dividend; sampled with start.
REQ-007 SHALL have port: src_b  in  32  multiplier or divisor; sampled with start.
REQ-008 SHALL have port: flush  in  1  pipeline flush or exception; aborts any operation in progress.
REQ-009 SHALL have port: hilo_rd  in  1  ID/EX holds an MFHI/MFLO that needs HI/LO.
REQ-010 SHALL have port: wr_hi, wr_lo  in  1 each  MTHI/MTLO write strobes.
REQ-011 SHALL have port: wr_data  in  32  MTHI/MTLO data.
REQ-012 SHALL have port: busy  out  1  high in PREP, CALC, FIXUP.
REQ-013 SHALL have port: stall  out  1  pipeline hold request.
REQ-014 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-015 SHALL have port: prod  out  64  {HI, LO} result register, feeding the HI/LO forwarding muxes.
REQ-016 SHALL have port: div_zero  out  1  high together with done when the completed divide had src_b==0.

Function
REQ-017 SHALL implement FSM states IDLE, PREP, CALC, FIXUP, DONE.
REQ-018 SHALL transition IDLE->PREP on start; in PREP, take operand magnitudes (signed ops) and record result signs.
REQ-019 SHALL transition PREP->CALC with a 5-bit iteration counter cleared to 0.
REQ-020 SHALL perform exactly one shift-add step (multiply) or one restoring shift-subtract step (divide) per CALC cycle, for 32 cycles, then transition to FIXUP.
REQ-021 SHALL, in FIXUP, apply sign correction and load prod, then transition to DONE.
REQ-022 SHALL apply these sign rules: MULT negates the 64-bit product when signs differ; DIV quotient sign = sign(a)^sign(b); remainder sign = sign(a).
REQ-023 SHALL place divide results as LO=quotient and HI=remainder, and multiply results as the full 64-bit product.
REQ-024 SHALL assert done for exactly the DONE cycle, 35 cycles after the edge that sampled start.
REQ-025 SHALL transition DONE->IDLE, or DONE->PREP when start is high (back-to-back).
REQ-026 SHALL, when EARLY_OUT=1 and the zero case applies, transition IDLE->DONE directly, so done appears the cycle after start.
REQ-027 SHALL, for a zero multiply operand, load prod=0.
REQ-028 SHALL, for divide by zero, load LO=32'hFFFFFFFF and HI=src_a, and assert div_zero with done; with EARLY_OUT=0 the iterative path SHALL produce the same values.
REQ-029 SHALL, for DIV 32'h80000000 / 32'hFFFFFFFF, produce LO=32'h80000000 and HI=0.
REQ-030 SHALL ignore start while busy.
REQ-031 SHALL drive stall = busy & (start | hilo_rd | wr_hi | wr_lo).
REQ-032 SHALL apply wr_hi/wr_lo only when not busy, writing prod[63:32] and prod[31:0] respectively.
REQ-033 SHALL, when a wr_hi/wr_lo coincides with FIXUP's prod load, give the FIXUP load priority (this cannot occur without stall).
REQ-034 SHALL, on flush, return to IDLE at the next edge from any state, leave prod unchanged, and suppress done.
REQ-035 SHALL give flush priority over start in the same cycle.
REQ-036 SHALL hold prod stable except on a FIXUP/early-out load or an MTHI/MTLO write.

Reset
REQ-037 SHALL, on rst_n low, immediately force state=IDLE, counter=0, prod=64'h0, busy=0, stall=0, done=0, div_zero=0, independent of clk.
REQ-038 SHALL, when reset asserts mid-operation, discard the operation with no done pulse.
REQ-039 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-040 SHALL cover MULT: a=-3 (32'hFFFFFFFD), b=7 -> done at cycle 35, prod=64'hFFFFFFFF_FFFFFFEB, busy high cycles 1-34.
REQ-041 SHALL cover DIV: a=-7, b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU a=100, b=7 -> LO=14, HI=2.
REQ-042 SHALL cover DIVU with b=0, EARLY_OUT=1: a=5 -> done at cycle 1, div_zero=1, LO=32'hFFFFFFFF, HI=5.
REQ-043 SHALL cover hilo_rd held high from cycle 3 of a MULTU -> stall high through cycle 34, low in the DONE cycle; prod is valid when stall drops.
REQ-044 SHALL cover flush at cycle 10 of a DIV, then rst_n low mid-operation -> IDLE, no done, prod keeps its previous value; after reset, prod=0.
REQ-045 SHALL cover wr_lo with 32'h12345678 while idle -> prod[31:0] updated next edge, prod[63:32] unchanged; the same write while busy -> stall=1 and no write.
